// File: rtl/axi_hs_throttle.sv
// axi_hs_throttle: per-channel valid/ready stall injector (pass, LFSR-random, periodic, block)
// that never withdraws a committed VALID. Stall counters exist only with AXI_HS_THROTTLE_STATS_EN.
module axi_hs_throttle #(
  parameter int          NCH    = 5,
  parameter int          PROB_W = 10,
  parameter int          CW     = 8,
  parameter logic [15:0] SEED   = 16'hACE1,
  parameter int          STAT_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NCH-1:0]            s_valid,
  output logic [NCH-1:0]            s_ready,
  output logic [NCH-1:0]            m_valid,
  input  logic [NCH-1:0]            m_ready,
  input  logic [2*NCH-1:0]          cfg_mode,
  input  logic [(PROB_W+1)*NCH-1:0] cfg_prob,
  input  logic [CW*NCH-1:0]         cfg_on,
  input  logic [CW*NCH-1:0]         cfg_off,
  input  logic                      stats_clr,
  output logic [STAT_W*NCH-1:0]     stall_cnt
);

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_RAND  = 2'd1,
    MODE_PER   = 2'd2,
    MODE_BLOCK = 2'd3
  } mode_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam logic [15:0] SEED_X = SEED ^ 16'(i);
    localparam logic [15:0] SEED_I = (SEED_X == 16'h0) ? 16'h1 : SEED_X;

    mode_e           mode;
    logic [PROB_W:0] prob;
    logic [CW:0]     on_w;
    logic [CW:0]     period;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [CW:0]     pc_q, pc_d;
    logic            allow_q, allow_d;
    logic            hold_q, hold_d;

    assign mode   = mode_e'(cfg_mode[2*i +: 2]);
    assign prob   = cfg_prob[(PROB_W+1)*i +: PROB_W+1];
    assign on_w   = {1'b0, cfg_on[CW*i +: CW]};
    // One bit wider than the operands so on+off can never wrap.
    assign period = on_w + {1'b0, cfg_off[CW*i +: CW]};

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0);
      pc_d   = pc_q + (CW+1)'(1);
      if (period == '0 || pc_q >= period - (CW+1)'(1)) pc_d = '0;
      allow_d = 1'b0;
      case (mode)
        MODE_RAND: allow_d = {1'b0, lfsr_q[PROB_W-1:0]} < prob;
        MODE_PER:  allow_d = (period == '0) || (pc_q < on_w);
        default:   allow_d = 1'b0;
      endcase
    end

    // Outputs forced low while rst is high so reset drops them immediately.
    assign m_valid[i] = ~rst & s_valid[i] & ((mode == MODE_PASS) | allow_q | hold_q);
    assign s_ready[i] = m_valid[i] & m_ready[i];
    // A stalled beat commits; a handshake or a dropped s_valid releases it.
    assign hold_d     = m_valid[i] & ~m_ready[i];

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        lfsr_q  <= SEED_I;
        pc_q    <= '0;
        allow_q <= 1'b0;
        hold_q  <= 1'b0;
      end else begin
        lfsr_q  <= lfsr_d;
        pc_q    <= pc_d;
        allow_q <= allow_d;
        hold_q  <= hold_d;
      end
    end

`ifdef AXI_HS_THROTTLE_STATS_EN
    logic [STAT_W-1:0] stall_q, stall_d;

    always_comb begin
      stall_d = stall_q;
      if (stats_clr)                                   stall_d = '0;
      else if (s_valid[i] && !s_ready[i] && !(&stall_q)) stall_d = stall_q + STAT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) stall_q <= '0;
      else     stall_q <= stall_d;
    end

    assign stall_cnt[STAT_W*i +: STAT_W] = stall_q;
`else
    assign stall_cnt[STAT_W*i +: STAT_W] = '0;
`endif
  end

`ifndef AXI_HS_THROTTLE_STATS_EN
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
`endif

endmodule

// File: tb/tb_axi_hs_throttle.sv
// Directed self-checking bench for axi_hs_throttle (default parameters); the stats scenario
// adapts to whether AXI_HS_THROTTLE_STATS_EN is defined.
`timescale 1ns/1ps
module tb_axi_hs_throttle;
  localparam int NCH    = 5;
  localparam int PROB_W = 10;
  localparam int CW     = 8;
  localparam int STAT_W = 32;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NCH-1:0]            s_valid, s_ready, m_valid, m_ready;
  logic [2*NCH-1:0]          cfg_mode;
  logic [(PROB_W+1)*NCH-1:0] cfg_prob;
  logic [CW*NCH-1:0]         cfg_on, cfg_off;
  logic                      stats_clr;
  logic [STAT_W*NCH-1:0]     stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axi_hs_throttle #(
    .NCH(NCH), .PROB_W(PROB_W), .CW(CW), .SEED(16'hACE1), .STAT_W(STAT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready),
    .m_valid(m_valid), .m_ready(m_ready),
    .cfg_mode(cfg_mode), .cfg_prob(cfg_prob),
    .cfg_on(cfg_on), .cfg_off(cfg_off),
    .stats_clr(stats_clr), .stall_cnt(stall_cnt)
  );

  task automatic set_ch(input int ch, input logic [1:0] mode, input logic [PROB_W:0] prob,
                        input logic [CW-1:0] on, input logic [CW-1:0] off);
    cfg_mode[2*ch +: 2]                 = mode;
    cfg_prob[(PROB_W+1)*ch +: PROB_W+1] = prob;
    cfg_on[CW*ch +: CW]                 = on;
    cfg_off[CW*ch +: CW]                = off;
  endtask

  task automatic clear_all();
    s_valid = '0; m_ready = '0; stats_clr = 1'b0;
    cfg_mode = '0; cfg_prob = '0; cfg_on = '0; cfg_off = '0;
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  // Returns at posedge+1 with rst low: the start of cycle 0 after release.
  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_all();
    s_valid = '1; m_ready = '1;
    rst = 1'b1; #1;
    n_tests++; if (m_valid !== '0) begin n_fail++; $display("FAIL rst_mvalid got=%b exp=00000", m_valid); end
    n_tests++; if (s_ready !== '0) begin n_fail++; $display("FAIL rst_sready got=%b exp=00000", s_ready); end
    n_tests++; if (stall_cnt !== '0) begin n_fail++; $display("FAIL rst_stall got=%h exp=0", stall_cnt); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_tests++; if (m_valid !== 5'b11111) begin n_fail++; $display("FAIL post_rst_mvalid got=%b exp=11111", m_valid); end
    n_tests++; if (s_ready !== 5'b11111) begin n_fail++; $display("FAIL post_rst_sready got=%b exp=11111", s_ready); end
    next_cyc();
  endtask

  task automatic test_pass();
    logic [7:0] sv_pat = 8'b1011_0010;
    logic [7:0] mr_pat = 8'b1110_0111;
    clear_all();
    set_ch(1, 2'd3, '0, '0, '0);
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      s_valid[0] = sv_pat[k]; m_ready[0] = mr_pat[k];
      s_valid[1] = 1'b1;      m_ready[1] = 1'b1;
      @(negedge clk);
      n_tests++; if (m_valid[0] !== sv_pat[k]) begin n_fail++;
        $display("FAIL pass_mvalid k=%0d got=%b exp=%b", k, m_valid[0], sv_pat[k]); end
      n_tests++; if (s_ready[0] !== (sv_pat[k] & mr_pat[k])) begin n_fail++;
        $display("FAIL pass_sready k=%0d got=%b exp=%b", k, s_ready[0], sv_pat[k] & mr_pat[k]); end
      n_tests++; if (m_valid[1] !== 1'b0) begin n_fail++;
        $display("FAIL block_mvalid k=%0d got=%b exp=0", k, m_valid[1]); end
      next_cyc();
    end
  endtask

  task automatic test_random_extremes();
    int cnt = 0;
    logic exp_v;
    clear_all();
    set_ch(0, 2'd1, 11'd0, '0, '0);
    s_valid[0] = 1'b1; m_ready[0] = 1'b1;
    apply_reset();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); if (m_valid[0]) cnt++;
      next_cyc();
    end
    n_tests++; if (cnt != 0) begin n_fail++; $display("FAIL rand_prob0 got=%0d exp=0 beats", cnt); end

    set_ch(0, 2'd1, 11'd1024, '0, '0);
    @(negedge clk);
    next_cyc();
    for (int j = 0; j < 20; j++) begin
      exp_v = (j % 3 != 0);
      s_valid[0] = exp_v;
      @(negedge clk);
      n_tests++; if (m_valid[0] !== exp_v) begin n_fail++;
        $display("FAIL rand_prob1024_mvalid j=%0d got=%b exp=%b", j, m_valid[0], exp_v); end
      n_tests++; if (s_ready[0] !== exp_v) begin n_fail++;
        $display("FAIL rand_prob1024_sready j=%0d got=%b exp=%b", j, s_ready[0], exp_v); end
      next_cyc();
    end

    set_ch(0, 2'd1, 11'd512, '0, '0);
    s_valid[0] = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10000; k++) begin
      @(negedge clk); if (m_valid[0]) cnt++;
      next_cyc();
    end
    n_tests++; if (cnt < 4500 || cnt > 5500) begin n_fail++;
      $display("FAIL rand_prob512_ratio got=%0d exp=4500..5500 of 10000", cnt); end
  endtask

  task automatic test_periodic();
    logic e0, e1;
    clear_all();
    set_ch(0, 2'd2, '0, 8'd2, 8'd3);
    set_ch(1, 2'd2, '0, 8'd0, 8'd0);
    set_ch(2, 2'd2, '0, 8'd0, 8'd3);
    s_valid = '1; m_ready = '1;
    apply_reset();
    for (int c = 0; c < 16; c++) begin
      e0 = (c >= 1) && (((c - 1) % 5) < 2);
      e1 = (c >= 1);
      @(negedge clk);
      n_tests++; if (s_ready[0] !== e0) begin n_fail++;
        $display("FAIL periodic_2_3 c=%0d got=%b exp=%b", c, s_ready[0], e0); end
      n_tests++; if (s_ready[1] !== e1) begin n_fail++;
        $display("FAIL periodic_zero_period c=%0d got=%b exp=%b", c, s_ready[1], e1); end
      n_tests++; if (m_valid[2] !== 1'b0) begin n_fail++;
        $display("FAIL periodic_on0 c=%0d got=%b exp=0", c, m_valid[2]); end
      next_cyc();
    end
  endtask

  task automatic test_sticky_hold();
    bit found = 0;
    clear_all();
    set_ch(0, 2'd1, 11'd512, '0, '0);
    s_valid[0] = 1'b1; m_ready[0] = 1'b0;
    apply_reset();
    for (int k = 0; k < 64 && !found; k++) begin
      @(negedge clk);
      if (m_valid[0]) found = 1;
      else next_cyc();
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL sticky_first_valid got=none exp=m_valid within 64 cycles"); end
    if (found) begin
      for (int k = 0; k < 20; k++) begin
        next_cyc(); @(negedge clk);
        n_tests++; if (m_valid[0] !== 1'b1 || s_ready[0] !== 1'b0) begin n_fail++;
          $display("FAIL sticky_hold k=%0d got=%b/%b exp=1/0 (m_valid/s_ready)", k, m_valid[0], s_ready[0]); end
      end
      next_cyc();
      m_ready[0] = 1'b1;
      @(negedge clk);
      n_tests++; if (s_ready[0] !== 1'b1) begin n_fail++;
        $display("FAIL sticky_handshake got=%b exp=1", s_ready[0]); end
    end
    next_cyc();
  endtask

  task automatic test_block_after_commit();
    clear_all();
    set_ch(0, 2'd1, 11'd1024, '0, '0);
    s_valid[0] = 1'b1; m_ready[0] = 1'b0;
    apply_reset();
    @(negedge clk);
    n_tests++; if (m_valid[0] !== 1'b0) begin n_fail++; $display("FAIL bac_cycle0 got=%b exp=0", m_valid[0]); end
    next_cyc(); @(negedge clk);
    n_tests++; if (m_valid[0] !== 1'b1) begin n_fail++; $display("FAIL bac_commit got=%b exp=1", m_valid[0]); end
    next_cyc();
    set_ch(0, 2'd3, '0, '0, '0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++; if (m_valid[0] !== 1'b1 || s_ready[0] !== 1'b0) begin n_fail++;
        $display("FAIL bac_held k=%0d got=%b/%b exp=1/0 (m_valid/s_ready)", k, m_valid[0], s_ready[0]); end
      next_cyc();
    end
    m_ready[0] = 1'b1;
    @(negedge clk);
    n_tests++; if (s_ready[0] !== 1'b1) begin n_fail++; $display("FAIL bac_complete got=%b exp=1", s_ready[0]); end
    for (int k = 0; k < 5; k++) begin
      next_cyc(); @(negedge clk);
      n_tests++; if (m_valid[0] !== 1'b0 || s_ready[0] !== 1'b0) begin n_fail++;
        $display("FAIL bac_blocked k=%0d got=%b/%b exp=0/0 (m_valid/s_ready)", k, m_valid[0], s_ready[0]); end
    end
    next_cyc();
  endtask

  task automatic test_reset_mid_stall();
    clear_all();
    set_ch(0, 2'd3, '0, '0, '0);
    s_valid[1:0] = 2'b11; m_ready[1:0] = 2'b11;
    apply_reset();
    repeat (5) next_cyc();
    n_tests++; if (m_valid[1:0] !== 2'b10) begin n_fail++; $display("FAIL pre_rst_mvalid got=%b exp=10", m_valid[1:0]); end
`ifdef AXI_HS_THROTTLE_STATS_EN
    n_tests++; if (stall_cnt[STAT_W-1:0] !== 32'd5) begin n_fail++;
      $display("FAIL pre_rst_stall got=%0d exp=5", stall_cnt[STAT_W-1:0]); end
`endif
    #2 rst = 1'b1; #1;
    n_tests++; if (m_valid !== '0 || s_ready !== '0) begin n_fail++;
      $display("FAIL mid_rst_outputs got=%b/%b exp=00000/00000 (m_valid/s_ready)", m_valid, s_ready); end
    n_tests++; if (stall_cnt !== '0) begin n_fail++; $display("FAIL mid_rst_stall got=%h exp=0", stall_cnt); end
    @(posedge clk); #1; rst = 1'b0;
    next_cyc();
  endtask

  task automatic test_stats();
    clear_all();
    set_ch(3, 2'd3, '0, '0, '0);
    apply_reset();
    s_valid[3] = 1'b1;
    repeat (7) next_cyc();
    s_valid[3] = 1'b0;
    @(negedge clk);
`ifdef AXI_HS_THROTTLE_STATS_EN
    n_tests++; if (stall_cnt[STAT_W*3 +: STAT_W] !== 32'd7) begin n_fail++;
      $display("FAIL stats_count7 got=%0d exp=7", stall_cnt[STAT_W*3 +: STAT_W]); end
    next_cyc();
    stats_clr = 1'b1; s_valid[3] = 1'b1;
    next_cyc();
    stats_clr = 1'b0; s_valid[3] = 1'b0;
    @(negedge clk);
    n_tests++; if (stall_cnt[STAT_W*3 +: STAT_W] !== 32'd0) begin n_fail++;
      $display("FAIL stats_clr_wins got=%0d exp=0", stall_cnt[STAT_W*3 +: STAT_W]); end
    next_cyc();
    s_valid[3] = 1'b1;
    repeat (2) next_cyc();
    s_valid[3] = 1'b0;
    @(negedge clk);
    n_tests++; if (stall_cnt[STAT_W*3 +: STAT_W] !== 32'd2) begin n_fail++;
      $display("FAIL stats_restart got=%0d exp=2", stall_cnt[STAT_W*3 +: STAT_W]); end
`else
    n_tests++; if (stall_cnt !== '0) begin n_fail++; $display("FAIL stats_disabled got=%h exp=0", stall_cnt); end
`endif
    next_cyc();
  endtask

  initial begin
    rst = 1'b1;
    clear_all();
    test_reset();
    test_pass();
    test_random_extremes();
    test_periodic();
    test_sticky_hold();
    test_block_after_commit();
    test_reset_mid_stall();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_hs_throttle.md
# axi_hs_throttle

Parametrised multi-channel valid/ready throttle. It sits between AXI masters (DMA engines) and the simulation RAM slaves, and injects stalls into any number of independent handshake channels (AR, R, AW, W, B, ...). Per channel it supports pass-through, LFSR-random, or periodic stall modes. Unlike combinational valid gating, it never withdraws a downstream VALID before its handshake completes, so the stalled traffic remains AXI-legal.

## Interface
Parameters:
- `NCH`, 5, number of independent valid/ready channels.
- `PROB_W`, 10, random-mode resolution; probability = `cfg_prob` / 2^`PROB_W`.
- `CW`, 8, width of periodic on/off cycle counts.
- `SEED`, 16'hACE1, base LFSR seed; channel i uses `SEED ^ i` (forced to 1 if zero).
- `STAT_W`, 32, stall-counter width.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `s_valid`  in  NCH  upstream VALID per channel.
- `s_ready`  out  NCH  upstream READY per channel.
- `m_valid`  out  NCH  downstream VALID per channel.
- `m_ready`  in  NCH  downstream READY per channel.
- `cfg_mode`  in  2*NCH  per channel: 0 = pass, 1 = random, 2 = periodic, 3 = block.
- `cfg_prob`  in  (PROB_W+1)*NCH  random-mode allow threshold, 0..2^PROB_W.
- `cfg_on`  in  CW*NCH  periodic allow cycles.
- `cfg_off`  in  CW*NCH  periodic stall cycles.
- `stats_clr`  in  1  synchronous clear of all stall counters.
- `stall_cnt`  out  STAT_W*NCH  per-channel stall cycles (only with `AXI_HS_THROTTLE_STATS_EN`).

Reset values: `m_valid` = 0, `s_ready` = 0, `stall_cnt` = 0, `allow_q` = 0, `hold_q` = 0, periodic counters = 0, LFSRs = seed.

Data and ID buses are not routed through this block. They pass directly from source to sink.

## Operation
Each channel i runs the following logic independently:
- **LFSR:** 16-bit Galois, taps 0xB400, advances every cycle. `rnd` = low `PROB_W` bits.
- **Periodic counter** `pc`: counts 0..`cfg_on`+`cfg_off`−1, then wraps to 0.
  - The sum is computed at CW+1 bits.
  - If `cfg_on`+`cfg_off` == 0, the counter holds at 0 and the channel always allows.
- **`allow_d` by mode:**
  - pass: don't-care; the gate is bypassed.
  - random: `rnd` < `cfg_prob`. Threshold 0 never allows; 2^PROB_W always allows.
  - periodic: `pc` < `cfg_on`.
  - block: 0.
- **`allow_q`** <= `allow_d`. This is a registered, one-cycle-late gate.
- **`hold_q`** (sticky commitment):
  - Set when `m_valid` & ~`m_ready`.
  - Cleared when `m_valid` & `m_ready`.
- **Outputs:**
  - Mode pass: `m_valid` = `s_valid`.
  - Otherwise: `m_valid` = `s_valid` & (`allow_q` | `hold_q`).
  - All modes: `s_ready` = `m_valid` & `m_ready`.
  - Upstream therefore handshakes exactly when downstream does. There is no buffering and no added latency on accepted beats.
- **Config changes:** mode or config changes take effect on the next `allow_q` update. A committed beat (`hold_q` = 1) completes even if the mode switches to block.
- **Upstream protocol:** upstream must itself obey AXI and not drop `s_valid` while `s_ready` = 0. If it does drop, `m_valid` follows `s_valid` low and `hold_q` clears.

## Timing
- Gate decision latency: 1 cycle from LFSR or counter state to `allow_q`.
- VALID/READY path: combinational, zero cycles. `m_valid` is combinational from `s_valid`; `s_ready` is combinational from `m_ready`.
- Channels never interact.
- Simultaneous events:
  - `allow_q` falling in the same cycle `hold_q` = 1: `m_valid` stays high.
  - Handshake on the same cycle `hold_q` would be set: the clear wins, so `hold_q` = 0 next cycle.
- `rst` asserted mid-transfer: all outputs drop to 0 asynchronously and all state returns to reset values. Partial bursts are lost; the bench re-issues them.
- `stats_clr` and an increment in the same cycle: the counter becomes 0.

## Configuration
- `AXI_HS_THROTTLE_STATS_EN` defined:
  - Per-channel counter increments on each cycle with `s_valid` & ~`s_ready`.
  - Saturates at 2^STAT_W−1.
  - Cleared by `stats_clr`.
- Undefined: the counters are not built, `stall_cnt` is tied to 0, and `stats_clr` is ignored.

## Test plan
- **Pass-through:** mode 0, `m_ready` = 1, `s_valid` toggling -> `m_valid` mirrors `s_valid` in the same cycle, and `s_ready` = `s_valid`.
- **Random extremes:** mode 1 with `cfg_prob` = 0 for 200 cycles -> `m_valid` never 1. Then `cfg_prob` = 1024 -> `m_valid` = `s_valid` from the second cycle onward. With `cfg_prob` = 512, the allow ratio over 10k cycles is within 0.45–0.55.
- **Periodic:** mode 2, `cfg_on` = 2, `cfg_off` = 3, `s_valid` = `m_ready` = 1 -> handshake pattern 1,1,0,0,0 repeating, shifted one cycle after reset release.
- **Sticky hold:** mode 1, `cfg_prob` = 512, `m_ready` held 0 for 20 cycles after the first `m_valid` -> `m_valid` stays 1 throughout. The handshake occurs on the first cycle `m_ready` = 1.
- **Block after commit:** `hold_q` = 1, then `cfg_mode` switched to 3 -> the current beat completes and no further `m_valid` is asserted.
- **Reset and stats:**
  - `rst` pulsed mid-stall -> `m_valid`, `s_ready` and `stall_cnt` are 0 immediately.
  - With `AXI_HS_THROTTLE_STATS_EN`, 7 stalled cycles -> `stall_cnt` = 7, and `stats_clr` -> 0.
